// File: rtl/servo_pkg.sv
// Shared types and saturating helpers for the multi-channel servo controller.
package servo_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        ABSOLUTE = 2'd1,
        VELOCITY = 2'd2
    } servo_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } upd_state_t;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Wide intermediate sum so an out-of-range step saturates instead of wrapping.
    function automatic int sat_add(input int pos, input int step, input int lo, input int hi);
        return clamp_int(pos + step, lo, hi);
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One PWM channel: pulse width is latched at the start of each period and compared
// against the shared period counter, so position changes never glitch a live pulse.
module servo_pwm_ch
    import servo_pkg::*;
#(
    parameter int CNT_W     = 11,
    parameter int POS_W     = 8,
    parameter int MIN_PULSE = 50,
    parameter int POS_INIT  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_period_cnt,
    input  logic             i_period_start,
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_en,
    output logic             o_servo
);

    logic [CNT_W-1:0] r_pw;
    logic             r_servo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pw    <= CNT_W'(MIN_PULSE + POS_INIT);
            r_servo <= 1'b0;
        end else begin
            if (i_period_start) begin
                r_pw <= CNT_W'(MIN_PULSE) + CNT_W'(i_pos);
            end
            r_servo <= i_en && (i_period_cnt < r_pw);
        end
    end

    assign o_servo = r_servo;

endmodule

// File: rtl/multi_servo_ctrl.sv
// N-channel hobby-servo controller: shared prescaler/period counter, per-channel PWM,
// and a sequential engine that moves each channel's position once per PWM period.
module multi_servo_ctrl
    import servo_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int POS_W     = 8,
    parameter int ADC_W     = 8,
    parameter int CLK_DIV   = 250,
    parameter int PERIOD    = 2000,
    parameter int MIN_PULSE = 50,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 200,
    parameter int POS_INIT  = 100,
    parameter int CENTER    = 'h26,
    parameter int DEADBAND  = 4,
    parameter int VEL_SHIFT = 4,
    parameter int MAX_STEP  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [2*N_CH-1:0]      mode,
    input  logic [ADC_W*N_CH-1:0]  joy,
    input  logic [N_CH-1:0]        joy_valid,
    input  logic [POS_W*N_CH-1:0]  target,
    input  logic [N_CH-1:0]        target_we,
    output logic [N_CH-1:0]        servo,
    output logic [POS_W*N_CH-1:0]  pos_out,
    output logic [N_CH-1:0]        at_limit,
    output logic                   period_start
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PRE_W-1:0] r_presc;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_pstart;
    upd_state_t       r_state, w_next_state;
    logic [IDX_W-1:0] r_idx, w_next_idx;
    logic [POS_W-1:0] r_pos [N_CH];
    logic [POS_W-1:0] r_tgt [N_CH];
    logic [ADC_W-1:0] r_joy [N_CH];
    logic [N_CH-1:0]  r_atlim;

    servo_mode_t      w_mode;
    int               w_ch;
    int               w_off;
    int               w_mag;
    int               w_step;
    logic [POS_W-1:0] w_new_pos;

    // period_start is registered so it is low out of reset and fires when the counters land on 0/0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_pcnt   <= '0;
            r_pstart <= 1'b0;
        end else begin
            if (r_presc == PRE_W'(CLK_DIV - 1)) begin
                r_presc <= '0;
                r_pcnt  <= (r_pcnt == CNT_W'(PERIOD - 1)) ? '0 : r_pcnt + CNT_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
            r_pstart <= (r_presc == PRE_W'(CLK_DIV - 1)) && (r_pcnt == CNT_W'(PERIOD - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            IDLE: begin
                if (r_pstart) begin
                    w_next_state = UPDATE;
                    w_next_idx   = '0;
                end
            end
            UPDATE: begin
                if (r_idx == IDX_W'(N_CH - 1)) begin
                    w_next_state = IDLE;
                    w_next_idx   = '0;
                end else begin
                    w_next_idx = r_idx + IDX_W'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_ch = int'(r_idx);

    // The joystick magnitude is shifted rather than the signed value, so the step
    // rounds toward zero and both stick directions move at the same rate.
    always_comb begin
        w_mode = servo_mode_t'(mode[2*w_ch +: 2]);
        w_off  = int'(r_joy[r_idx]) - CENTER;
        w_mag  = 0;
        w_step = 0;
        case (w_mode)
            ABSOLUTE: begin
                w_step = clamp_int(int'(r_tgt[r_idx]) - int'(r_pos[r_idx]), -MAX_STEP, MAX_STEP);
            end
            VELOCITY: begin
                w_mag = (w_off < 0) ? -w_off : w_off;
                if (w_mag > DEADBAND) begin
                    w_mag = w_mag >> VEL_SHIFT;
                    if (w_mag == 0) begin
                        w_mag = 1;
                    end
                    w_step = clamp_int((w_off < 0) ? -w_mag : w_mag, -MAX_STEP, MAX_STEP);
                end
            end
            default: w_step = 0;
        endcase
        w_new_pos = POS_W'(sat_add(int'(r_pos[r_idx]), w_step, POS_MIN, POS_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_pos[i] <= POS_W'(POS_INIT);
                r_tgt[i] <= POS_W'(POS_INIT);
                r_joy[i] <= ADC_W'(CENTER);
            end
            r_atlim <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (target_we[i]) begin
                    r_tgt[i] <= POS_W'(clamp_int(int'(target[i*POS_W +: POS_W]), POS_MIN, POS_MAX));
                end
                if (joy_valid[i]) begin
                    r_joy[i] <= joy[i*ADC_W +: ADC_W];
                end
                if ((r_state == UPDATE) && en && (r_idx == IDX_W'(i))) begin
                    r_pos[i] <= w_new_pos;
                end
                r_atlim[i] <= (r_pos[i] == POS_W'(POS_MIN)) || (r_pos[i] == POS_W'(POS_MAX));
            end
        end
    end

    assign period_start = r_pstart;
    assign at_limit     = r_atlim;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign pos_out[g*POS_W +: POS_W] = r_pos[g];

        servo_pwm_ch #(
            .CNT_W     (CNT_W),
            .POS_W     (POS_W),
            .MIN_PULSE (MIN_PULSE),
            .POS_INIT  (POS_INIT)
        ) u_pwm (
            .clk            (clk),
            .reset          (reset),
            .i_period_cnt   (r_pcnt),
            .i_period_start (r_pstart),
            .i_pos          (r_pos[g]),
            .i_en           (en),
            .o_servo        (servo[g])
        );
    end

endmodule

// File: tb/tb_multi_servo_ctrl.sv
// Scoreboard bench for multi_servo_ctrl: a per-period behavioural model predicts pulse
// widths, positions and limit flags; a monitor checks them on every period_start.
module tb_multi_servo_ctrl;

    localparam int N_CH      = 2;
    localparam int POS_W     = 8;
    localparam int ADC_W     = 8;
    localparam int CLK_DIV   = 2;
    localparam int PERIOD    = 300;
    localparam int MIN_PULSE = 50;
    localparam int POS_MIN   = 0;
    localparam int POS_MAX   = 200;
    localparam int POS_INIT  = 100;
    localparam int CENTER    = 'h26;
    localparam int DEADBAND  = 4;
    localparam int VEL_SHIFT = 4;
    localparam int MAX_STEP  = 8;
    localparam int PCLK      = CLK_DIV * PERIOD;
    localparam int NPER      = 94;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic [2*N_CH-1:0]     mode;
    logic [ADC_W*N_CH-1:0] joy;
    logic [N_CH-1:0]       joy_valid;
    logic [POS_W*N_CH-1:0] target;
    logic [N_CH-1:0]       target_we;
    logic [N_CH-1:0]       servo;
    logic [POS_W*N_CH-1:0] pos_out;
    logic [N_CH-1:0]       at_limit;
    logic                  period_start;

    always #5 clk = ~clk;

    multi_servo_ctrl #(
        .N_CH(N_CH), .POS_W(POS_W), .ADC_W(ADC_W), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD),
        .MIN_PULSE(MIN_PULSE), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .CENTER(CENTER), .DEADBAND(DEADBAND), .VEL_SHIFT(VEL_SHIFT), .MAX_STEP(MAX_STEP)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .joy(joy), .joy_valid(joy_valid),
        .target(target), .target_we(target_we), .servo(servo), .pos_out(pos_out),
        .at_limit(at_limit), .period_start(period_start)
    );

    typedef struct {
        int pos0, pos1, hi0, hi1, lim0, lim1;
    } rec_t;

    rec_t sbq[$];
    int   passCount  = 0;
    int   checkCount = 0;
    bit   resetDone  = 1'b0;
    bit   monDone    = 1'b0;

    int   mPos[N_CH];
    int   mTgt[N_CH];
    int   mJoy[N_CH];
    int   mMode[N_CH];
    bit   mEn;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Movement for one period according to the channel's mode, straight from the rules.
    function automatic int modelNext(input int ch);
        int off, s;
        s = 0;
        if (mMode[ch] == 1) begin
            s = lim(mTgt[ch] - mPos[ch], -MAX_STEP, MAX_STEP);
        end else if (mMode[ch] == 2) begin
            off = mJoy[ch] - CENTER;
            if (off > DEADBAND || off < -DEADBAND) begin
                s = off / (1 << VEL_SHIFT);
                if (s == 0) s = (off > 0) ? 1 : -1;
                s = lim(s, -MAX_STEP, MAX_STEP);
            end
        end
        return lim(mPos[ch] + s, POS_MIN, POS_MAX);
    endfunction

    task automatic waitPstart(input int limit, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Drives one period's stimulus (mid-pulse writes, late enable change) and queues the prediction.
    task automatic applyStimulus(input int k);
        int  md[N_CH], tv[N_CH], jv[N_CH];
        bit  wt[N_CH], wj[N_CH];
        bit  e;
        int  w;
        rec_t r;
        for (int i = 0; i < N_CH; i++) begin
            md[i] = mMode[i]; wt[i] = 1'b0; wj[i] = 1'b0; tv[i] = 0; jv[i] = 0;
        end
        e = mEn;
        if (k == 4)  begin md[0] = 1; wt[0] = 1'b1; tv[0] = 200; end
        if (k == 10) begin wt[0] = 1'b1; tv[0] = 250; end
        if (k == 19) begin md[1] = 2; wj[1] = 1'b1; jv[1] = 'h28; end
        if (k == 23) begin wj[1] = 1'b1; jv[1] = 'hFF; end
        if (k == 37) begin e = 1'b0; wj[1] = 1'b1; jv[1] = 'h00; end
        if (k == 40) begin e = 1'b1; md[1] = 1; wt[1] = 1'b1; tv[1] = 10; wt[0] = 1'b1; tv[0] = 37; end
        if (k == 64) begin md[1] = 2; end
        if (k >= 70) begin
            for (int i = 0; i < N_CH; i++) begin
                md[i] = $urandom_range(0, 3);
                wt[i] = 1'($urandom_range(0, 1));
                tv[i] = $urandom_range(0, 255);
                wj[i] = 1'($urandom_range(0, 1));
                jv[i] = $urandom_range(0, 255);
            end
            e = ($urandom_range(0, 7) != 0) || (k == NPER);
        end

        w = $urandom_range(20, 80);
        repeat (w) @(negedge clk);
        for (int i = 0; i < N_CH; i++) begin
            mode[2*i +: 2]          = 2'(md[i]);
            target[i*POS_W +: POS_W] = POS_W'(tv[i]);
            joy[i*ADC_W +: ADC_W]    = ADC_W'(jv[i]);
            target_we[i]             = wt[i];
            joy_valid[i]             = wj[i];
        end
        @(negedge clk);
        target_we = '0;
        joy_valid = '0;
        repeat (560 - w - 1) @(negedge clk);
        en = e;

        for (int i = 0; i < N_CH; i++) begin
            mMode[i] = md[i];
            if (wt[i]) mTgt[i] = lim(tv[i], POS_MIN, POS_MAX);
            if (wj[i]) mJoy[i] = jv[i];
        end
        mEn = e;
        r.hi0 = mEn ? (MIN_PULSE + mPos[0]) * CLK_DIV : 0;
        r.hi1 = mEn ? (MIN_PULSE + mPos[1]) * CLK_DIV : 0;
        if (mEn) begin
            for (int i = 0; i < N_CH; i++) mPos[i] = modelNext(i);
        end
        r.pos0 = mPos[0];
        r.pos1 = mPos[1];
        r.lim0 = (mPos[0] == POS_MIN || mPos[0] == POS_MAX) ? 1 : 0;
        r.lim1 = (mPos[1] == POS_MIN || mPos[1] == POS_MAX) ? 1 : 0;
        sbq.push_back(r);
    endtask

    initial begin : stimulus
        bit ok;
        int n;
        reset = 1'b1; en = 1'b1; mode = '0; joy = {N_CH{ADC_W'(CENTER)}};
        joy_valid = '0; target = '0; target_we = '0;
        for (int i = 0; i < N_CH; i++) begin
            mPos[i] = POS_INIT; mTgt[i] = POS_INIT; mJoy[i] = CENTER; mMode[i] = 0;
        end
        mEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_servo", int'(servo), 0);
        checkOutput("reset_pos", int'(pos_out), (POS_INIT << POS_W) | POS_INIT);
        checkOutput("reset_at_limit", int'(at_limit), 0);
        checkOutput("reset_period_start", int'(period_start), 0);
        reset = 1'b0;
        resetDone = 1'b1;

        for (int k = 1; k <= NPER; k++) begin
            if (k > 1) begin
                waitPstart(2 * PCLK, ok);
                if (!ok) begin
                    checkOutput("stim_pstart_timeout", 0, 1);
                    break;
                end
            end
            applyStimulus(k);
        end
        wait (monDone);

        // One clock after period_start: the update engine is running and every pulse is high.
        @(negedge clk);
        checkOutput("servo_before_reset", int'(servo), 3);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_servo", int'(servo), 0);
        checkOutput("async_reset_pos", int'(pos_out), (POS_INIT << POS_W) | POS_INIT);
        checkOutput("async_reset_at_limit", int'(at_limit), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (n < 2 * PCLK && !period_start) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_period_after_reset", n, PCLK);
        checkOutput("pos_after_reset", int'(pos_out), (POS_INIT << POS_W) | POS_INIT);
        @(negedge clk);
        checkOutput("period_start_one_cycle", int'(period_start), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin : monitor
        bit   ok;
        int   hi0, hi1, cyc;
        rec_t cur;
        wait (resetDone);
        waitPstart(2 * PCLK, ok);
        if (!ok) checkOutput("mon_first_pstart_timeout", 0, 1);
        for (int j = 1; ok && j <= NPER; j++) begin
            if (sbq.size() == 0) begin
                checkOutput("scoreboard_empty", 0, 1);
                break;
            end
            cur = sbq.pop_front();
            hi0 = 0; hi1 = 0; cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                hi0 += int'(servo[0]);
                hi1 += int'(servo[1]);
                if (cyc == 10) begin
                    checkOutput($sformatf("pos0_p%0d", j), int'(pos_out[0 +: POS_W]), cur.pos0);
                    checkOutput($sformatf("pos1_p%0d", j), int'(pos_out[POS_W +: POS_W]), cur.pos1);
                    checkOutput($sformatf("at_limit0_p%0d", j), int'(at_limit[0]), cur.lim0);
                    checkOutput($sformatf("at_limit1_p%0d", j), int'(at_limit[1]), cur.lim1);
                end
            end while (!period_start && cyc < 2 * PCLK);
            checkOutput($sformatf("period_len_p%0d", j), cyc, PCLK);
            checkOutput($sformatf("pulse0_p%0d", j), hi0, cur.hi0);
            checkOutput($sformatf("pulse1_p%0d", j), hi1, cur.hi1);
            ok = period_start;
        end
        monDone = 1'b1;
    end

    initial begin : watchdog
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
